// File: rtl/pipelined_barrel_rotator.sv
// pipelined_barrel_rotator
//   Variable-amount circular rotator. One registered logarithmic stage per
//   amount bit; stage k rotates by 2^k when amount bit k is set. Valid/ready
//   on both sides, one word per cycle, full backpressure.
//
//   Build option: define ROT_DIR_EN to add the up_dir port (0 = right,
//   1 = left), carried per word through every stage. Without it, every word
//   rotates right.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     up_valid/up_ready   upstream handshake
//     up_data [N-1:0]     word to rotate
//     up_amt  [SW-1:0]    rotate amount 0..N-1
//     up_dir              direction (ROT_DIR_EN builds only)
//     down_valid/ready    downstream handshake
//     down_data [N-1:0]   rotated word, straight from the last stage register

// Combinational rotate by the fixed amount 2^K, enabled by en.
module pipelined_barrel_rotator_stage #(
    parameter int N = 8,
    parameter int K = 0
) (
    input  logic [N-1:0] a,
    input  logic         en,
`ifdef ROT_DIR_EN
    input  logic         dir,
`endif
    output logic [N-1:0] y
);
    localparam int S = 1 << K;

    logic [N-1:0] rr;
    // right: y[i] = a[(i + S) mod N]
    assign rr = {a[S-1:0], a[N-1:S]};

`ifdef ROT_DIR_EN
    logic [N-1:0] rl;
    // left: y[i] = a[(i - S) mod N]
    assign rl = {a[N-S-1:0], a[N-1:N-S]};
    assign y  = !en ? a : (dir ? rl : rr);
`else
    assign y  = en ? rr : a;
`endif
endmodule

module pipelined_barrel_rotator #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
`ifdef ROT_DIR_EN
    input  logic          up_dir,
`endif
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);
    typedef struct packed {
        logic [N-1:0]  data;
        logic [SW-1:0] amt;
`ifdef ROT_DIR_EN
        logic          dir;
`endif
    } stage_t;

    // Index 0 is the upstream port, index k+1 is the register of stage k.
    logic   vld_pipe [SW:0];
    stage_t pipe     [SW:0];
    stage_t up_s;

    // go[k]: stage k may load this cycle (empty, or its content leaves).
    // go[SW] is the downstream acceptance.
    logic [SW:0] go;

    always_comb begin
        up_s      = '0;
        up_s.data = up_data;
        up_s.amt  = up_amt;
`ifdef ROT_DIR_EN
        up_s.dir  = up_dir;
`endif
    end

    assign vld_pipe[0] = up_valid;
    assign pipe[0]     = up_s;

    // Ready ripples back from the output so a stalled chain fills completely
    // and a released chain accepts in the same cycle.
    always_comb begin
        go     = '0;
        go[SW] = down_ready;
        for (int k = SW - 1; k >= 0; k--)
            go[k] = !vld_pipe[k+1] || go[k+1];
    end

    for (genvar k = 0; k < SW; k++) begin : g_stage
        logic [N-1:0] rot;

        pipelined_barrel_rotator_stage #(.N(N), .K(k)) u_rot (
            .a   (pipe[k].data),
            .en  (pipe[k].amt[k]),
`ifdef ROT_DIR_EN
            .dir (pipe[k].dir),
`endif
            .y   (rot)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe[k+1] <= 1'b0;
                pipe[k+1]     <= '0;
            end else if (go[k]) begin
                vld_pipe[k+1] <= vld_pipe[k];
                // payload only moves with a real word; bubbles leave it alone
                if (vld_pipe[k]) begin
                    pipe[k+1]      <= pipe[k];
                    pipe[k+1].data <= rot;
                end
            end
        end
    end

    assign up_ready   = go[0];
    assign down_valid = vld_pipe[SW];
    assign down_data  = pipe[SW].data;

    // The last stage's amount/dir copies have no consumer.
    logic pipe_unused;
`ifdef ROT_DIR_EN
    assign pipe_unused = ^{pipe[SW].amt, pipe[SW].dir};
`else
    assign pipe_unused = ^pipe[SW].amt;
`endif
endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
module tb_pipelined_barrel_rotator;
    localparam int N   = 8;
    localparam int SW  = $clog2(N);
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [N-1:0]  up_data = '0;
    logic [SW-1:0] up_amt = '0;
`ifdef ROT_DIR_EN
    logic          up_dir = 1'b0;
`endif
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [N-1:0]  down_data;

    pipelined_barrel_rotator #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
`ifdef ROT_DIR_EN
        .up_dir     (up_dir),
`endif
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int fails  = 0;
    bit lat_chk = 1'b0;
    bit done    = 1'b0;

    typedef struct {
        logic [N-1:0] d;
        int           c;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: circular rotate by r as plain shifts.
    function automatic logic [N-1:0] model(input logic [N-1:0] a, input int r, input bit left);
        logic [N-1:0] res;
        if (left) res = (a << r) | (a >> (N - r));
        else      res = (a >> r) | (a << (N - r));
        return res;
    endfunction

    task automatic push_exp(input logic [N-1:0] e);
        exp_t x;
        x.d = e;
        x.c = cyc;
        sb.push_back(x);
    endtask

    // Present a word at the next falling edge and hold it until accepted.
    task automatic send(input logic [N-1:0] d, input int r, input bit left, input logic [N-1:0] e);
        int waited = 0;
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = d;
        up_amt   = SW'(r);
`ifdef ROT_DIR_EN
        up_dir   = left;
`else
        if (left) $display("warn: left rotation requested in a right-only build");
`endif
        #1;
        while (!up_ready && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!up_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: up_ready=%0b, want 1 within 1000 cycles", up_ready);
        end else begin
            push_exp(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compares every output transfer against the scoreboard.
    initial begin : monitor
        logic         held_v;
        logic [N-1:0] held_d;
        exp_t         e;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", down_valid, 1);
                    chk("hold_data", down_data, held_d);
                end
                if (down_valid && down_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL spurious_output: got %0h, want no output", down_data);
                    end else begin
                        e = sb.pop_front();
                        chk("data", down_data, e.d);
                        if (lat_chk) chk("latency", cyc - e.c, LAT);
                    end
                end
                held_v = down_valid && !down_ready;
                held_d = down_data;
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] stream_exp [8] = '{8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04};

    initial begin : stim
        logic [N-1:0] d;
        int           r;
        int           acc;

        // reset state
        #1;
        chk("rst_down_valid", down_valid, 0);
        chk("rst_down_data", down_data, 0);
        chk("rst_up_ready", up_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_down_valid", down_valid, 0);
        chk("post_rst_up_ready", up_ready, 1);

        // directed values
        down_ready = 1'b1;
        lat_chk    = 1'b1;
        send(8'hA3, 3, 1'b0, 8'h74);
        idle();
        drain();
        send(8'hA3, 0, 1'b0, 8'hA3);
        send(8'h01, 7, 1'b0, 8'h02);
        idle();
        drain();
`ifdef ROT_DIR_EN
        send(8'hA3, 3, 1'b1, 8'h1D);
        send(8'h80, 1, 1'b1, 8'h01);
        idle();
        drain();
`endif

        // streaming, one word per cycle
        for (int i = 1; i <= 8; i++) begin
            send(N'(i), 1, 1'b0, stream_exp[i-1]);
            chk("stream_up_ready", up_ready, 1);
        end
        idle();
        drain();

        // backpressure fill and release
        lat_chk = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            down_ready = 1'b0;
            d = N'($urandom);
            r = $urandom_range(0, N - 1);
            up_valid = 1'b1;
            up_data  = d;
            up_amt   = SW'(r);
`ifdef ROT_DIR_EN
            up_dir   = 1'b0;
`endif
            #1;
            if (up_ready) begin
                acc++;
                push_exp(model(d, r, 1'b0));
            end
        end
        chk("bp_accepted", acc, SW);
        chk("bp_up_ready_low", up_ready, 0);
        @(negedge clk);
        down_ready = 1'b1;
        d = N'($urandom);
        r = $urandom_range(0, N - 1);
        up_data = d;
        up_amt  = SW'(r);
        #1;
        chk("bp_release_ready", up_ready, 1);
        if (up_ready) push_exp(model(d, r, 1'b0));
        idle();
        drain();

        // reset with words in flight
        down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = N'($urandom);
            r = $urandom_range(0, N - 1);
            send(d, r, 1'b0, model(d, r, 1'b0));
        end
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_down_valid", down_valid, 0);
        chk("midrst_down_data", down_data, 0);
        chk("midrst_up_ready", up_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("post_midrst_idle", down_valid, 0);
        end
        lat_chk = 1'b1;
        d = N'($urandom);
        r = $urandom_range(0, N - 1);
        send(d, r, 1'b0, model(d, r, 1'b0));
        idle();
        drain();

        // random handshakes
        lat_chk = 1'b0;
        fork
            begin : rnd_src
                logic [N-1:0] rd;
                int           rr;
                bit           rl;
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    rd = N'($urandom);
                    rr = $urandom_range(0, N - 1);
                    rl = 1'b0;
`ifdef ROT_DIR_EN
                    rl = 1'($urandom_range(0, 1));
`endif
                    send(rd, rr, rl, model(rd, rr, rl));
                end
                idle();
                done = 1'b1;
            end
            begin : rnd_sink
                while (!done) begin
                    @(negedge clk);
                    down_ready = ($urandom_range(0, 3) != 0);
                end
                down_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
